ibex_ipm_gf_mul: RTL

// - Multicycle responder behind the EX-block IPM port.
// - Computes lane-wise GF(2^8) products (AES polynomial) on four byte lanes, for inner-product-masking code.
// - Fixed, data-independent latency, so masked software never leaks through timing.
// - Handshake matches the multdiv units: dynamic enable, static select, ready from ID.

---
 rtl/ibex_pkg.sv | 34 +++
 rtl/ibex_ipm_gf_step.sv | 13 +
 rtl/ibex_ipm_gf_mul.sv | 137 +++++++++++++
 3 files changed

// File: rtl/ibex_pkg.sv
// Shared types and GF(2^8) helpers for the inner-product-masking multiplier.
package ibex_pkg;

  typedef enum logic [1:0] {
    IPM_OP_MUL = 2'd0,
    IPM_OP_SQ  = 2'd1,
    IPM_OP_IP  = 2'd2
  } ipm_op_e;

  typedef enum logic [1:0] {
    IPM_IDLE,
    IPM_CALC,
    IPM_DONE
  } ipm_fsm_e;

  localparam logic [7:0] IPM_GF_POLY = 8'h1B;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] ipm_xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? IPM_GF_POLY : 8'h00);
  endfunction

  // Final result formatting from the four lane accumulators.
  function automatic logic [31:0] ipm_result(input ipm_op_e op, input logic [31:0] acc);
    logic [31:0] res;
    case (op)
      IPM_OP_MUL, IPM_OP_SQ: res = acc;
      IPM_OP_IP:             res = {24'h0, acc[7:0] ^ acc[15:8] ^ acc[23:16] ^ acc[31:24]};
      default:               res = 32'h0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/ibex_ipm_gf_step.sv
// One Horner step for one byte lane: acc' = x*acc + bit*a in GF(2^8).
module ibex_ipm_gf_step
  import ibex_pkg::*;
(
  input  logic [7:0] acc_i,
  input  logic [7:0] a_i,
  input  logic       bit_i,
  output logic [7:0] acc_o
);

  assign acc_o = ipm_xtime(acc_i) ^ (bit_i ? a_i : 8'h00);

endmodule

// File: rtl/ibex_ipm_gf_mul.sv
// Fixed-latency lane-wise GF(2^8) multiplier / squarer / inner product.
module ibex_ipm_gf_mul
  import ibex_pkg::*;
#(
  parameter int unsigned ItersPerCycle = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  ipm_op_e     ipm_operator_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        ipm_en_i,
  input  logic        ipm_sel_i,
  input  logic        ipm_ready_id_i,
  output logic [31:0] result_o,
  output logic        valid_o
);

  localparam int unsigned NumLanes = 4;
  localparam logic [3:0]  CountMax = 4'd8;
  localparam logic [3:0]  CountInc = 4'(ItersPerCycle);

  ipm_fsm_e        state_q, state_d;
  logic [3:0]      count_q, count_d;
  logic [3:0][7:0] a_q, a_d;
  logic [3:0][7:0] b_q, b_d;
  ipm_op_e         op_q, op_d;
  logic [3:0][7:0] acc_q, acc_d;
  logic [31:0]     result_q, result_d;
  logic            valid_q, valid_d;

  logic [3:0][7:0] acc_step;
  logic [4:0]      count_sum;
  logic [2:0]      bit_idx [ItersPerCycle];
  logic [7:0]      chain   [NumLanes][ItersPerCycle+1];

  // Bit of b consumed by each chained step this cycle, MSB first.
  for (genvar j = 0; j < ItersPerCycle; j++) begin : g_idx
    assign bit_idx[j] = 3'(7 - j) - count_q[2:0];
  end

  // Per-lane chain of Horner steps; lanes never interact.
  for (genvar k = 0; k < NumLanes; k++) begin : g_lane
    assign chain[k][0] = acc_q[k];
    for (genvar j = 0; j < ItersPerCycle; j++) begin : g_iter
      ibex_ipm_gf_step u_step (
        .acc_i (chain[k][j]),
        .a_i   (a_q[k]),
        .bit_i (b_q[k][bit_idx[j]]),
        .acc_o (chain[k][j+1])
      );
    end
    assign acc_step[k] = chain[k][ItersPerCycle];
  end

  assign count_sum = 5'(count_q) + 5'(CountInc);

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    acc_d    = acc_q;
    result_d = 32'h0;
    valid_d  = 1'b0;

    case (state_q)
      IPM_IDLE: begin
        if (ipm_en_i && ipm_sel_i) begin
          a_d     = a_i;
          b_d     = (ipm_operator_i == IPM_OP_SQ) ? a_i : b_i;
          op_d    = ipm_operator_i;
          acc_d   = '0;
          count_d = 4'd0;
          state_d = IPM_CALC;
        end
      end
      IPM_CALC: begin
        if (!ipm_sel_i) begin
          acc_d   = '0;
          count_d = 4'd0;
          state_d = IPM_IDLE;
        end else begin
          acc_d   = acc_step;
          count_d = (count_sum >= 5'(CountMax)) ? CountMax : count_sum[3:0];
          if (count_sum >= 5'(CountMax)) begin
            state_d  = IPM_DONE;
            valid_d  = 1'b1;
            result_d = ipm_result(op_q, acc_step);
          end
        end
      end
      IPM_DONE: begin
        if (!ipm_sel_i) begin
          acc_d   = '0;
          count_d = 4'd0;
          state_d = IPM_IDLE;
        end else if (ipm_ready_id_i) begin
          state_d = IPM_IDLE;
        end else begin
          valid_d  = 1'b1;
          result_d = result_q;
        end
      end
      default: state_d = IPM_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IPM_IDLE;
      count_q  <= 4'd0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= IPM_OP_MUL;
      acc_q    <= '0;
      result_q <= 32'h0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign result_o = result_q;
  assign valid_o  = valid_q;

endmodule
